// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: opcodes, functs, ALU codes,
// datapath mux selects and the FSM state type.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP,
        S_ERROR, S_TRAP
    } state_e;

    // States that hold a memory request open and therefore run the timeout counter.
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and memory ack in, mux/enable/ALU selects out.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       memtoreg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       bus_err;
    logic       trap;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_write, reg_dst, memtoreg, alu_src_a, alu_src_b, ext_zero, alu_ctrl,
               instr_done, bus_err, trap
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_write, reg_dst, memtoreg, alu_src_a, alu_src_b, ext_zero, alu_ctrl,
               instr_done, bus_err, trap
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// mips_alu_decode: combinational (opcode, funct) -> ALU operation, immediate extension, legality.
// Shared with the single-cycle top.
module mips_alu_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       ext_zero,
    output logic       legal
);
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        alu_ctrl = ALU_ADD;
        ext_zero = 1'b0;
        legal    = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: legal    = 1'b0;
                endcase
            end
            OP_ADDI:      alu_ctrl = ALU_ADD;
            OP_SLTI:      alu_ctrl = ALU_SLT;
            OP_ANDI: begin
                alu_ctrl = ALU_AND;
                ext_zero = 1'b1;
            end
            OP_ORI: begin
                alu_ctrl = ALU_OR;
                ext_zero = 1'b1;
            end
            OP_LW, OP_SW: alu_ctrl = ALU_ADD;
            OP_BEQ:       alu_ctrl = ALU_SUB;
            OP_J:         alu_ctrl = ALU_ADD;
            default:      legal    = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory-timeout ERROR state.
// Define MIPS_ILLEGAL_TRAP_EN to trap on illegal instructions instead of treating them as NOPs.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);
    state_e          state_q, state_d;
    logic [5:0]      op_q, op_d;
    logic [5:0]      funct_q, funct_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic [5:0] dec_op, dec_funct;
    logic [2:0] dec_alu;
    logic       dec_ez, dec_legal;
    logic       timeout_hit;

    // In DECODE the live IR fields are decoded; afterwards only the captured copies matter.
    assign dec_op    = (state_q == S_DECODE) ? bus.opcode : op_q;
    assign dec_funct = (state_q == S_DECODE) ? bus.funct  : funct_q;

    mips_alu_decode u_alu_decode (
        .op       (dec_op),
        .funct    (dec_funct),
        .alu_ctrl (dec_alu),
        .ext_zero (dec_ez),
        .legal    (dec_legal)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && is_mem_wait(state_q) && !bus.mem_ready &&
                         (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        funct_d           = funct_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = PCSRC_ALU;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.memtoreg      = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.ext_zero      = 1'b0;
        bus.alu_ctrl      = ALU_AND;
        bus.instr_done    = 1'b0;
        bus.bus_err       = 1'b0;
        bus.trap          = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.alu_ctrl  = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH;
                bus.alu_ctrl  = ALU_ADD;
                op_d          = bus.opcode;
                funct_d       = bus.funct;
                if (!dec_legal) begin
`ifdef MIPS_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
`endif
                end else begin
                    case (bus.opcode)
                        OP_RTYPE:                         state_d = S_R_EXEC;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                        OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                        OP_BEQ:                           state_d = S_BRANCH;
                        OP_J:                             state_d = S_JUMP;
                        default:                          state_d = S_FETCH;
                    endcase
                end
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_RT;
                bus.alu_ctrl  = dec_alu;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_zero  = dec_ez;
                bus.alu_ctrl  = dec_alu;
                state_d       = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_ctrl  = ALU_ADD;
                state_d       = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.memtoreg   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_src_b     = SRCB_RT;
                bus.alu_ctrl      = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = PCSRC_ALUOUT;
                bus.instr_done    = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = PCSRC_JUMP;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_ERROR: bus.bus_err = 1'b1;
            S_TRAP: begin
`ifdef MIPS_ILLEGAL_TRAP_EN
                bus.trap = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Counter only survives a cycle spent waiting in the same memory state.
        to_cnt_d = '0;
        if (is_mem_wait(state_q) && !bus.mem_ready && (state_d == state_q))
            to_cnt_d = to_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            funct_q  <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            funct_q  <= funct_d;
            to_cnt_q <= to_cnt_d;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes per-cycle expected control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       memtoreg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_ctrl;
        logic       instr_done;
        logic       bus_err;
        logic       trap;
    } ctl_t;

    typedef enum {
        P_ZERO, P_FETCH_WAIT, P_FETCH_RDY, P_DECODE, P_DECODE_ILL, P_R_EXEC, P_R_WB,
        P_I_EXEC, P_I_WB, P_MEM_ADDR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE_WAIT,
        P_MEM_WRITE_RDY, P_BRANCH, P_JUMP, P_ERROR, P_TRAP
    } phase_e;

    logic clk = 1'b0;
    logic rst_n;
    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ctl_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    ctl_t  act;

    assign act = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.memtoreg,
                  bus.alu_src_a, bus.alu_src_b, bus.ext_zero, bus.alu_ctrl, bus.instr_done,
                  bus.bus_err, bus.trap};

    // Expected control word for each step, written from the controller's state table.
    function automatic ctl_t exp_of(input phase_e p, input logic [2:0] alu, input logic ez);
        ctl_t e;
        e = '0;
        case (p)
            P_ZERO: ;
            P_FETCH_WAIT, P_FETCH_RDY: begin
                e.mem_read  = 1'b1;
                e.alu_src_b = 2'b01;
                e.alu_ctrl  = 3'b010;
                if (p == P_FETCH_RDY) begin
                    e.ir_write = 1'b1;
                    e.pc_write = 1'b1;
                end
            end
            P_DECODE, P_DECODE_ILL: begin
                e.alu_src_b  = 2'b11;
                e.alu_ctrl   = 3'b010;
                e.instr_done = (p == P_DECODE_ILL);
            end
            P_R_EXEC: begin
                e.alu_src_a = 1'b1;
                e.alu_ctrl  = alu;
            end
            P_R_WB: begin
                e.reg_write  = 1'b1;
                e.reg_dst    = 1'b1;
                e.instr_done = 1'b1;
            end
            P_I_EXEC: begin
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                e.ext_zero  = ez;
                e.alu_ctrl  = alu;
            end
            P_I_WB: begin
                e.reg_write  = 1'b1;
                e.instr_done = 1'b1;
            end
            P_MEM_ADDR: begin
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                e.alu_ctrl  = 3'b010;
            end
            P_MEM_READ: begin
                e.mem_read = 1'b1;
                e.i_or_d   = 1'b1;
            end
            P_MEM_WB: begin
                e.reg_write  = 1'b1;
                e.memtoreg   = 1'b1;
                e.instr_done = 1'b1;
            end
            P_MEM_WRITE_WAIT, P_MEM_WRITE_RDY: begin
                e.mem_write  = 1'b1;
                e.i_or_d     = 1'b1;
                e.instr_done = (p == P_MEM_WRITE_RDY);
            end
            P_BRANCH: begin
                e.alu_src_a     = 1'b1;
                e.alu_ctrl      = 3'b011;
                e.pc_write_cond = 1'b1;
                e.pc_src        = 2'b01;
                e.instr_done    = 1'b1;
            end
            P_JUMP: begin
                e.pc_write   = 1'b1;
                e.pc_src     = 2'b10;
                e.instr_done = 1'b1;
            end
            P_ERROR: e.bus_err = 1'b1;
            P_TRAP:  e.trap    = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle of stimulus: drive mem_ready, record expectation, advance.
    task automatic step(input phase_e p, input logic mr, input string nm,
                        input logic [2:0] alu = 3'b000, input logic ez = 1'b0);
        bus.mem_ready = mr;
        exp_q.push_back(exp_of(p, alu, ez));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input string nm);
        bus.opcode = op;
        bus.funct  = fn;
        step(P_FETCH_RDY, 1'b1, {nm, "_fetch"});
        step(P_DECODE, 1'b0, {nm, "_decode"});
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        step(P_ZERO, 1'b0, {nm, "_rst"});
        rst_n = 1'b1;
        step(P_ZERO, 1'b0, {nm, "_idle"});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ctl_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at %0t", nm, act, e, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n         = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset and the one-cycle IDLE gap
        step(P_ZERO, 1'b1, "reset0");
        step(P_ZERO, 1'b1, "reset1");
        rst_n = 1'b1;
        step(P_ZERO, 1'b1, "idle");

        // add; IR changes after DECODE must be ignored
        fetch_decode(6'h00, 6'h20, "add");
        bus.opcode = 6'h3F;
        bus.funct  = 6'h22;
        step(P_R_EXEC, 1'b1, "add_exec", 3'b010);
        step(P_R_WB, 1'b1, "add_wb");

        // sub with two fetch wait cycles; slt, and, or
        bus.opcode = 6'h00;
        bus.funct  = 6'h22;
        step(P_FETCH_WAIT, 1'b0, "sub_fwait0");
        step(P_FETCH_WAIT, 1'b0, "sub_fwait1");
        fetch_decode(6'h00, 6'h22, "sub");
        step(P_R_EXEC, 1'b0, "sub_exec", 3'b011);
        step(P_R_WB, 1'b0, "sub_wb");
        fetch_decode(6'h00, 6'h2A, "slt");
        step(P_R_EXEC, 1'b0, "slt_exec", 3'b100);
        step(P_R_WB, 1'b0, "slt_wb");
        fetch_decode(6'h00, 6'h24, "and");
        step(P_R_EXEC, 1'b0, "and_exec", 3'b000);
        step(P_R_WB, 1'b0, "and_wb");
        fetch_decode(6'h00, 6'h25, "or");
        step(P_R_EXEC, 1'b0, "or_exec", 3'b001);
        step(P_R_WB, 1'b0, "or_wb");

        // I-type: ori/andi zero-extend, addi/slti sign-extend
        fetch_decode(6'h0D, 6'h00, "ori");
        bus.opcode = 6'h08;
        step(P_I_EXEC, 1'b0, "ori_exec", 3'b001, 1'b1);
        step(P_I_WB, 1'b0, "ori_wb");
        fetch_decode(6'h08, 6'h3F, "addi");
        step(P_I_EXEC, 1'b0, "addi_exec", 3'b010, 1'b0);
        step(P_I_WB, 1'b0, "addi_wb");
        fetch_decode(6'h0C, 6'h00, "andi");
        step(P_I_EXEC, 1'b0, "andi_exec", 3'b000, 1'b1);
        step(P_I_WB, 1'b0, "andi_wb");
        fetch_decode(6'h0A, 6'h00, "slti");
        step(P_I_EXEC, 1'b0, "slti_exec", 3'b100, 1'b0);
        step(P_I_WB, 1'b0, "slti_wb");

        // lw with three wait cycles in MEM_READ
        fetch_decode(6'h23, 6'h00, "lw");
        bus.opcode = 6'h2B;
        step(P_MEM_ADDR, 1'b0, "lw_addr");
        for (int i = 0; i < 3; i++) step(P_MEM_READ, 1'b0, "lw_rwait");
        step(P_MEM_READ, 1'b1, "lw_rdy");
        step(P_MEM_WB, 1'b0, "lw_wb");

        // sw with one wait cycle, then zero-wait sw
        fetch_decode(6'h2B, 6'h00, "sw");
        step(P_MEM_ADDR, 1'b0, "sw_addr");
        step(P_MEM_WRITE_WAIT, 1'b0, "sw_wwait");
        step(P_MEM_WRITE_RDY, 1'b1, "sw_rdy");
        fetch_decode(6'h2B, 6'h00, "sw0");
        step(P_MEM_ADDR, 1'b1, "sw0_addr");
        step(P_MEM_WRITE_RDY, 1'b1, "sw0_rdy");

        // beq and j: three cycles each
        fetch_decode(6'h04, 6'h00, "beq");
        step(P_BRANCH, 1'b0, "beq_branch");
        fetch_decode(6'h02, 6'h00, "j");
        step(P_JUMP, 1'b0, "j_jump");

        // Reset asserted mid MEM_READ aborts immediately
        fetch_decode(6'h23, 6'h00, "lwrst");
        step(P_MEM_ADDR, 1'b0, "lwrst_addr");
        step(P_MEM_READ, 1'b0, "lwrst_rwait");
        do_reset("lwrst");
        step(P_FETCH_WAIT, 1'b0, "after_rst_fetch");

        // Illegal instructions: op 3F and R-type funct 21
        bus.opcode = 6'h3F;
        bus.funct  = 6'h00;
        step(P_FETCH_RDY, 1'b1, "ill_fetch");
`ifdef MIPS_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step(i == 0 ? P_DECODE : P_TRAP, 1'b1, "ill_trap");
        step(P_TRAP, 1'b1, "ill_trap_held");
        do_reset("ill");
`else
        step(P_DECODE_ILL, 1'b0, "ill_nop");
        bus.opcode = 6'h00;
        bus.funct  = 6'h21;
        step(P_FETCH_RDY, 1'b1, "illfn_fetch");
        step(P_DECODE_ILL, 1'b0, "illfn_nop");
`endif

        // Fetch timeout: 16 low cycles -> sticky ERROR
        for (int i = 0; i < 16; i++) step(P_FETCH_WAIT, 1'b0, "to_wait");
        step(P_ERROR, 1'b1, "to_err0");
        step(P_ERROR, 1'b1, "to_err1");
        step(P_ERROR, 1'b0, "to_err2");
        do_reset("to");

        // mem_ready on the 16th cycle wins over the timeout
        bus.opcode = 6'h02;
        bus.funct  = 6'h00;
        for (int i = 0; i < 15; i++) step(P_FETCH_WAIT, 1'b0, "edge_wait");
        step(P_FETCH_RDY, 1'b1, "edge_rdy");
        step(P_DECODE, 1'b0, "edge_decode");
        step(P_JUMP, 1'b0, "edge_jump");

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
